branch_resolve_unit: RTL

Two-stage pipelined branch resolution unit for the out-of-order core's branch functional unit. It takes an issued control-flow op (conditional branch, JAL or JALR) from the branch reservation station and evaluates the condition. It computes the target, compares the outcome against the front-end prediction and returns the result to the ROB. The result includes a mispredict flag and a redirect PC. It generalises the single-cycle combinational comparator into a width-parametrised, back-pressured, flushable pipeline with target generation and misprediction detection.

---
 rtl/branch_resolve_unit_pkg.sv | 41 ++++
 rtl/branch_resolve_unit_cmp.sv | 32 +++
 rtl/branch_resolve_unit.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/branch_resolve_unit_pkg.sv
// Shared types for the branch functional unit: op kinds, branch conditions,
// the packed result record returned to the ROB and a small alignment helper.
package branch_resolve_unit_pkg;

    localparam int unsigned BR_DATA_W = 32;
    localparam int unsigned BR_TAG_W  = 5;

    typedef enum logic [1:0] {
        BR_COND = 2'd0,
        BR_JAL  = 2'd1,
        BR_JALR = 2'd2
    } br_kind_t;

    // RV32I B-type funct3 encodings; 3'b010 and 3'b011 are not defined.
    typedef enum logic [2:0] {
        F3_BEQ  = 3'b000,
        F3_BNE  = 3'b001,
        F3_BLT  = 3'b100,
        F3_BGE  = 3'b101,
        F3_BLTU = 3'b110,
        F3_BGEU = 3'b111
    } branch_funct3_t;

    // Result record at the default widths, as seen by the ROB.
    typedef struct packed {
        logic [BR_TAG_W-1:0]  tag;
        logic                 taken;
        logic [BR_DATA_W-1:0] target;
        logic [BR_DATA_W-1:0] link;
        logic                 mispredict;
        logic [BR_DATA_W-1:0] redirect_pc;
        logic                 exc;
    } br_res_t;

    // Without the C extension a taken target must be 4-byte aligned; bit 1
    // is the one that can be set by a legal even immediate.
    function automatic logic br_target_misaligned(input logic [1:0] low_bits);
        return low_bits[1];
    endfunction

endpackage

// File: rtl/branch_resolve_unit_cmp.sv
// Combinational funct3 comparator used in stage 1 of the branch unit.
module branch_cmp
    import branch_resolve_unit_pkg::*;
#(
    parameter int unsigned DATA_W = 32
) (
    input  branch_funct3_t    funct3,
    input  logic [DATA_W-1:0] rs1,
    input  logic [DATA_W-1:0] rs2,
    output logic              cmp,
    output logic              illegal
);

    // Evaluate the branch condition; undefined encodings flag illegal and never take.
    always_comb begin
        cmp     = 1'b0;
        illegal = 1'b0;
        case (funct3)
            F3_BEQ:  cmp = (rs1 == rs2);
            F3_BNE:  cmp = (rs1 != rs2);
            F3_BLT:  cmp = ($signed(rs1) <  $signed(rs2));
            F3_BGE:  cmp = ($signed(rs1) >= $signed(rs2));
            F3_BLTU: cmp = (rs1 <  rs2);
            F3_BGEU: cmp = (rs1 >= rs2);
            default: begin
                cmp     = 1'b0;
                illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/branch_resolve_unit.sv
// Two-stage branch resolution pipeline: S1 holds the issued op and resolves
// direction/target, S2 holds the finished result presented to the ROB.
module branch_resolve_unit
    import branch_resolve_unit_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned TAG_W  = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  br_kind_t          in_kind,
    input  branch_funct3_t    in_funct3,
    input  logic [DATA_W-1:0] in_rs1,
    input  logic [DATA_W-1:0] in_rs2,
    input  logic [DATA_W-1:0] in_pc,
    input  logic [DATA_W-1:0] in_imm,
    input  logic              in_pred_taken,
    input  logic [DATA_W-1:0] in_pred_target,
    input  logic [TAG_W-1:0]  in_tag,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [TAG_W-1:0]  out_tag,
    output logic              out_taken,
    output logic [DATA_W-1:0] out_target,
    output logic [DATA_W-1:0] out_link,
    output logic              out_mispredict,
    output logic [DATA_W-1:0] out_redirect_pc,
    output logic              out_exc
);

    typedef struct packed {
        br_kind_t          kind;
        branch_funct3_t    funct3;
        logic [DATA_W-1:0] rs1;
        logic [DATA_W-1:0] rs2;
        logic [DATA_W-1:0] pc;
        logic [DATA_W-1:0] imm;
        logic              pred_taken;
        logic [DATA_W-1:0] pred_target;
        logic [TAG_W-1:0]  tag;
    } s1_op_t;

    // Same field layout as br_res_t, sized by this instance's parameters.
    typedef struct packed {
        logic [TAG_W-1:0]  tag;
        logic              taken;
        logic [DATA_W-1:0] target;
        logic [DATA_W-1:0] link;
        logic              mispredict;
        logic [DATA_W-1:0] redirect_pc;
        logic              exc;
    } res_t;

    logic   s1_valid_q, s1_valid_d;
    s1_op_t s1_op_q,    s1_op_d;
    logic   s2_valid_q, s2_valid_d;
    res_t   s2_res_q,   s2_res_d;
    res_t   s1_res_s;
    logic   cmp_s, illegal_s;
    logic   s1_advance_s, in_ready_s;

    branch_cmp #(.DATA_W(DATA_W)) u_cmp (
        .funct3  (s1_op_q.funct3),
        .rs1     (s1_op_q.rs1),
        .rs2     (s1_op_q.rs2),
        .cmp     (cmp_s),
        .illegal (illegal_s)
    );

    // S1 may move into S2 whenever S2 is empty or handing its result off.
    assign s1_advance_s = !s2_valid_q || out_ready;
    assign in_ready_s   = !s1_valid_q || s1_advance_s;

    // Resolve direction, target, link and misprediction for the op held in S1.
    always_comb begin
        logic exc_op;
        s1_res_s      = '0;
        exc_op        = 1'b0;
        s1_res_s.tag  = s1_op_q.tag;
        s1_res_s.link = s1_op_q.pc + DATA_W'(4);
        case (s1_op_q.kind)
            BR_COND: begin
                s1_res_s.taken  = cmp_s && !illegal_s;
                s1_res_s.target = s1_op_q.pc + s1_op_q.imm;
                exc_op          = illegal_s;
            end
            BR_JAL: begin
                s1_res_s.taken  = 1'b1;
                s1_res_s.target = s1_op_q.pc + s1_op_q.imm;
            end
            BR_JALR: begin
                s1_res_s.taken  = 1'b1;
                s1_res_s.target = (s1_op_q.rs1 + s1_op_q.imm) & ~DATA_W'(1);
            end
            default: begin
                // Unencoded kind: treat as a non-taken faulting op.
                s1_res_s.taken  = 1'b0;
                s1_res_s.target = s1_op_q.pc + s1_op_q.imm;
                exc_op          = 1'b1;
            end
        endcase
        s1_res_s.exc = exc_op ||
            (s1_res_s.taken && br_target_misaligned(s1_res_s.target[1:0]));
        // A faulting op redirects through the trap path, never as a mispredict.
        s1_res_s.mispredict = !s1_res_s.exc &&
            ((s1_res_s.taken != s1_op_q.pred_taken) ||
             (s1_res_s.taken && (s1_res_s.target != s1_op_q.pred_target)));
        s1_res_s.redirect_pc = s1_res_s.taken ? s1_res_s.target : s1_res_s.link;
    end

    // Next-state for both stages: flush kills, otherwise valid/ready handshakes.
    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_op_d    = s1_op_q;
        s2_valid_d = s2_valid_q;
        s2_res_d   = s2_res_q;
        if (flush) begin
            s1_valid_d = 1'b0;
            s2_valid_d = 1'b0;
        end else begin
            if (s1_advance_s) begin
                s2_valid_d = s1_valid_q;
                if (s1_valid_q) begin
                    s2_res_d = s1_res_s;
                end else begin
                    s2_res_d = s2_res_q;
                end
            end else begin
                s2_valid_d = s2_valid_q;
            end
            if (in_ready_s) begin
                s1_valid_d = in_valid;
                if (in_valid) begin
                    s1_op_d = '{kind: in_kind, funct3: in_funct3, rs1: in_rs1,
                                rs2: in_rs2, pc: in_pc, imm: in_imm,
                                pred_taken: in_pred_taken,
                                pred_target: in_pred_target, tag: in_tag};
                end else begin
                    s1_op_d = s1_op_q;
                end
            end else begin
                s1_valid_d = s1_valid_q;
            end
        end
    end

    // Pipeline state; reset empties both stages and clears the result fields.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_op_q    <= '0;
            s2_valid_q <= 1'b0;
            s2_res_q   <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_op_q    <= s1_op_d;
            s2_valid_q <= s2_valid_d;
            s2_res_q   <= s2_res_d;
        end
    end

    assign in_ready        = in_ready_s;
    assign out_valid       = s2_valid_q;
    assign out_tag         = s2_res_q.tag;
    assign out_taken       = s2_res_q.taken;
    assign out_target      = s2_res_q.target;
    assign out_link        = s2_res_q.link;
    assign out_mispredict  = s2_res_q.mispredict;
    assign out_redirect_pc = s2_res_q.redirect_pc;
    assign out_exc         = s2_res_q.exc;

endmodule
